// File: rtl/approx_mul_arbiter.sv
// Two-requester round-robin front end for one shared multicycle multiplier.
// Operands are held in registers while the multiplier settles for LAT clocks.
module approx_mul_arbiter #(
   parameter int unsigned N   = 32,
   parameter int unsigned LAT = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   input  logic [N-1:0]   req0_a,
   input  logic [N-1:0]   req0_b,
   output logic           req0_ready,
   input  logic           req1_valid,
   input  logic [N-1:0]   req1_a,
   input  logic [N-1:0]   req1_b,
   output logic           req1_ready,
   output logic [N-1:0]   mul_x,
   output logic [N-1:0]   mul_y,
   input  logic [2*N-1:0] mul_p,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic           resp_id,
   output logic [2*N-1:0] resp_p,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       last_grant;
   logic       owner;
   logic       grant0;
   logic       grant1;

   // Ties go to whoever was not served last; readiness is forced low during reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && state == IDLE) begin
         if (req0_valid && (!req1_valid || last_grant))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         mul_x      <= '0;
         mul_y      <= '0;
         resp_p     <= '0;
         resp_id    <= 1'b0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  mul_x      <= grant1 ? req1_a : req0_a;
                  mul_y      <= grant1 ? req1_b : req0_b;
                  owner      <= grant1;
                  last_grant <= grant1;
                  cnt        <= CNT_LOAD;
                  state      <= CALC;
               end
            end
            CALC: begin
               // The product is taken verbatim once the settle window has elapsed.
               if (cnt == 4'd0) begin
                  resp_p  <= mul_p;
                  resp_id <= owner;
                  state   <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Directed bench: expected responses are queued at issue time and checked by
// per-instance monitors at each response handshake.
module tb_approx_mul_arbiter;

   localparam int N = 32;

   typedef struct packed {
      logic        id;
      logic [63:0] p;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // instance with LAT=2
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [N-1:0]  req0_a, req0_b, req1_a, req1_b, mul_x, mul_y;
   logic [63:0]   mul_p, resp_p;
   logic          resp_valid, resp_ready, resp_id, busy;

   // instance with LAT=1
   logic          f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
   logic [N-1:0]  f_req0_a, f_req0_b, f_req1_a, f_req1_b, f_mul_x, f_mul_y;
   logic [63:0]   f_mul_p, f_resp_p;
   logic          f_resp_valid, f_resp_ready, f_resp_id, f_busy;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int   n_tests = 0;
   int   n_fail  = 0;

   assign mul_p   = {32'b0, mul_x} * {32'b0, mul_y};
   assign f_mul_p = {32'b0, f_mul_x} * {32'b0, f_mul_y};

   always #5 clk = ~clk;

   approx_mul_arbiter #(.N(N), .LAT(2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_p(resp_p),
      .busy(busy)
   );

   approx_mul_arbiter #(.N(N), .LAT(1)) u_dut_f (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(f_req0_valid), .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_ready(f_req0_ready),
      .req1_valid(f_req1_valid), .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_ready(f_req1_ready),
      .mul_x(f_mul_x), .mul_y(f_mul_y), .mul_p(f_mul_p),
      .resp_valid(f_resp_valid), .resp_ready(f_resp_ready), .resp_id(f_resp_id), .resp_p(f_resp_p),
      .busy(f_busy)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drain_q1(input string name);
      for (int i = 0; i < 30 && q1.size() > 0; i++) next_cycle();
      chk(name, q1.size(), 0);
   endtask

   // monitors
   always @(negedge clk) begin
      if (resp_valid && resp_ready) begin
         if (q1.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL u1_unexpected_resp: got id %0d p 0x%0h, expected no response", resp_id, resp_p);
         end else begin
            e1 = q1.pop_front();
            chk("u1_resp_id", resp_id, e1.id);
            chk("u1_resp_p", resp_p, e1.p);
         end
      end
   end

   always @(negedge clk) begin
      if (f_resp_valid && f_resp_ready) begin
         if (q2.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL u2_unexpected_resp: got id %0d p 0x%0h, expected no response", f_resp_id, f_resp_p);
         end else begin
            e2 = q2.pop_front();
            chk("u2_resp_id", f_resp_id, e2.id);
            chk("u2_resp_p", f_resp_p, e2.p);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  t0, t1, acc;
      logic found;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      resp_ready = 1'b1;
      f_req0_valid = 1'b0; f_req1_valid = 1'b0;
      f_req0_a = '0; f_req0_b = '0; f_req1_a = '0; f_req1_b = '0;
      f_resp_ready = 1'b1;

      // reset values, with requests pending
      mid();
      chk("rst_mul_x", mul_x, 0);
      chk("rst_mul_y", mul_y, 0);
      chk("rst_resp_p", resp_p, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);

      // a) req0 only, 3*5, LAT=2
      next_cycle();
      rst_n = 1'b1;
      req1_valid = 1'b0;
      req0_a = 32'd3; req0_b = 32'd5;
      q1.push_back('{id: 1'b0, p: 64'd15});
      mid();
      chk("a_req0_ready", req0_ready, 1);
      chk("a_req1_ready", req1_ready, 0);
      next_cycle();
      req0_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) next_cycle();
         mid();
         chk("a_resp_valid", resp_valid, (c == 3));
         chk("a_mul_x_hold", mul_x, 3);
      end
      drain_q1("a_drain");

      // b) tie from reset: req0 first, second accept LAT+2 later
      next_cycle();
      rst_n = 1'b0;
      mid();
      next_cycle();
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9;
      req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd11;
      q1.push_back('{id: 1'b0, p: 64'd63});
      q1.push_back('{id: 1'b1, p: 64'd22});
      t0 = -1; t1 = -1;
      for (int c = 0; c < 40 && t1 < 0; c++) begin
         if (c > 0) begin
            next_cycle();
            if (t0 >= 0) req0_valid = 1'b0;
         end
         mid();
         chk("b_no_overlap", req0_ready && req1_ready, 0);
         if (req0_ready && req0_valid) t0 = c;
         if (req1_ready && req1_valid) t1 = c;
      end
      next_cycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("b_first_accept", t0, 0);
      chk("b_interval", t1 - t0, 4);
      drain_q1("b_drain");

      // c) continuous tie for four transactions
      req0_valid = 1'b1; req1_valid = 1'b1;
      q1.push_back('{id: 1'b0, p: 64'd63});
      q1.push_back('{id: 1'b1, p: 64'd22});
      q1.push_back('{id: 1'b0, p: 64'd63});
      q1.push_back('{id: 1'b1, p: 64'd22});
      acc = 0;
      for (int c = 0; c < 80 && acc < 4; c++) begin
         if (c > 0) next_cycle();
         mid();
         chk("c_no_overlap", req0_ready && req1_ready, 0);
         if (req0_ready && req0_valid) acc++;
         if (req1_ready && req1_valid) acc++;
      end
      next_cycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("c_accepts", acc, 4);
      drain_q1("c_drain");

      // d) max operands, consumer stalls in RESP
      req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
      resp_ready = 1'b0;
      q1.push_back('{id: 1'b0, p: 64'hFFFF_FFFE_0000_0001});
      mid();
      chk("d_req0_ready", req0_ready, 1);
      next_cycle();
      req0_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         mid();
         if (resp_valid) begin
            found = 1'b1;
            break;
         end
         next_cycle();
      end
      chk("d_resp_seen", found, 1);
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         if (k == 0) begin
            req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd11;
         end
         mid();
         chk("d_hold_valid", resp_valid, 1);
         chk("d_hold_p", resp_p, 64'hFFFF_FFFE_0000_0001);
         chk("d_hold_id", resp_id, 0);
         chk("d_busy", busy, 1);
         chk("d_req0_ready", req0_ready, 0);
         chk("d_req1_ready", req1_ready, 0);
         chk("d_mul_x_hold", mul_x, 32'hFFFF_FFFF);
      end
      next_cycle();
      resp_ready = 1'b1;
      q1.push_back('{id: 1'b1, p: 64'd22});
      mid();
      next_cycle();
      mid();
      chk("d_idle_busy", busy, 0);
      chk("d_idle_valid", resp_valid, 0);
      chk("d_next_accept", req1_ready, 1);
      next_cycle();
      req1_valid = 1'b0;
      drain_q1("d_drain");

      // e) reset during CALC abandons the operation
      req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4;
      mid();
      chk("e_req1_ready", req1_ready, 1);
      next_cycle();
      req1_valid = 1'b0;
      mid();
      chk("e_busy_calc", busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("e_rst_mul_x", mul_x, 0);
      chk("e_rst_mul_y", mul_y, 0);
      chk("e_rst_resp_p", resp_p, 0);
      chk("e_rst_resp_id", resp_id, 0);
      chk("e_rst_resp_valid", resp_valid, 0);
      chk("e_rst_busy", busy, 0);
      chk("e_rst_ready", {req0_ready, req1_ready}, 0);
      next_cycle();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         mid();
         chk("e_no_resp", resp_valid, 0);
         next_cycle();
      end
      req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9;
      req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd11;
      q1.push_back('{id: 1'b0, p: 64'd63});
      mid();
      chk("e_tie_req0", req0_ready, 1);
      chk("e_tie_req1", req1_ready, 0);
      next_cycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain_q1("e_drain");

      // f) LAT=1 instance, req1 only
      f_req1_valid = 1'b1; f_req1_a = 32'h1_0000; f_req1_b = 32'h1_0000;
      q2.push_back('{id: 1'b1, p: 64'h1_0000_0000});
      mid();
      chk("f_req1_ready", f_req1_ready, 1);
      chk("f_req0_ready", f_req0_ready, 0);
      for (int c = 1; c <= 3; c++) begin
         next_cycle();
         if (c == 1) f_req1_valid = 1'b0;
         mid();
         chk("f_resp_valid", f_resp_valid, (c == 2));
      end
      for (int i = 0; i < 10 && q2.size() > 0; i++) next_cycle();
      chk("f_drain", q2.size(), 0);

      next_cycle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/approx_mul_arbiter.md
APPROX_MUL_ARBITER -- requirements
Module: approx_mul_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N    32   operand width; product width is 2N
  LAT  2    multicycle settle time of the shared combinational multiplier, in clocks; legal range 1..15
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk         in   1    single clock; all state updates on the rising edge
  rst_n       in   1    asynchronous, active-low reset
  req0_valid  in   1    requester 0 has an operand pair
  req0_a      in   N    requester 0 multiplicand
  req0_b      in   N    requester 0 multiplier
  req0_ready  out  1    requester 0 pair accepted this cycle
  req1_valid  in   1    requester 1 has an operand pair
  req1_a      in   N    requester 1 multiplicand
  req1_b      in   N    requester 1 multiplier
  req1_ready  out  1    requester 1 pair accepted this cycle
  mul_x       out  N    operand register driving the shared approximate Booth multiplier x
  mul_y       out  N    operand register driving the shared multiplier y
  mul_p       in   2N   product returned by the shared multiplier
  resp_valid  out  1    result available
  resp_ready  in   1    consumer takes result
  resp_id     out  1    index of the requester that owns resp_p
  resp_p      out  2N   captured product
  busy        out  1    high in any state other than IDLE
REQ-003 The block SHALL have one clock, clk, and one asynchronous active-low reset, rst_n.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, CALC, and RESP.
REQ-005 In IDLE, the arbiter SHALL select a winner combinationally: if only one reqN_valid is high, that requester wins; if both are high, the requester not granted last wins (round-robin).
REQ-006 reqN_ready SHALL be high only in IDLE, only for the winner, and never for both requesters in the same cycle.
REQ-007 On an accept (reqN_valid && reqN_ready), the block SHALL load reqN_a into mul_x, load reqN_b into mul_y, set the owner id to N, update the last-grant pointer to N, load the counter with LAT-1, and enter CALC.
REQ-008 mul_x and mul_y SHALL hold stable from accept until the next accept; they SHALL never change in CALC or RESP.
REQ-009 In CALC, the counter SHALL decrement each cycle; in the cycle where the counter is 0, the block SHALL capture mul_p into resp_p and resp_id, and enter RESP.
REQ-010 Latency SHALL be fixed: for an accept in cycle T, resp_valid SHALL first be high in cycle T+LAT+1; with LAT=1, the capture occurs in the first CALC cycle.
REQ-011 In RESP, resp_valid SHALL be high, and resp_p and resp_id SHALL be held until resp_ready is sampled high; the FSM SHALL then return to IDLE.
REQ-012 There SHALL be no IDLE bypass: after a RESP handshake in cycle R, the earliest next accept SHALL be in cycle R+1, giving a minimum issue interval of LAT+2 cycles.
REQ-013 Requests arriving during CALC or RESP SHALL be stalled (ready low), not dropped; requesters hold valid and operands until ready.
REQ-014 The block SHALL perform no arithmetic on mul_p; the approximation error of the shared multiplier passes through unchanged, and the full 2N bits are captured with no truncation.
REQ-015 A request that deasserts valid while ready is low SHALL have no effect; a requester's own withdrawal SHALL NOT change the last-grant pointer.

Reset
REQ-016 While rst_n is low, the outputs SHALL be: state IDLE; counter 0; mul_x=0; mul_y=0; resp_p=0; resp_id=0; resp_valid=0; busy=0; req0_ready=0; req1_ready=0.
REQ-017 On reset, the last-grant pointer SHALL be set to 1, so requester 0 wins the first tie.
REQ-018 Reset asserted in CALC or RESP SHALL abandon the operation; no response is issued for it after release.
REQ-019 The first accept SHALL be possible in the first clock edge with rst_n high.

Verification
REQ-020 The bench SHALL drive mul_p from an exact-product stub (mul_x*mul_y) and SHALL cover these directed scenarios:
  a) LAT=2, req0 only, a=3, b=5, resp_ready=1 -> req0_ready high in cycle 0; resp_valid high in cycle 3 only; resp_p=15; resp_id=0.
  b) Both valid from reset, req0 (7,9), req1 (2,11), resp_ready=1 -> grants req0 first (resp 63, id 0), then req1 (resp 22, id 1); the second accept occurs exactly LAT+2 cycles after the first.
  c) Both valid continuously for 4 transactions -> resp_id sequence is 0,1,0,1; no ready overlap.
  d) resp_ready=0 for 5 cycles in RESP, a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_p=0xFFFFFFFE00000001 held stable; busy=1; both ready low; IDLE follows the handshake.
  e) rst_n low in CALC, req1 (4,4) -> all outputs are 0 immediately; no resp_valid after release; the next tie grants req0.
  f) LAT=1, req1 only, a=0x10000, b=0x10000 -> resp_valid in cycle 2; resp_p=0x100000000; resp_id=1.
